// File: rtl/ecdsa_pkg.sv
// Shared ECDSA datapath definitions: field width, projective point at
// infinity, scheduler state encoding and adder operation type.
package ecdsa_pkg;

  localparam int FIELD_W = 381;

  // Point at infinity in projective coordinates: (0 : 1 : 0)
  localparam logic [FIELD_W-1:0] INF_X = {FIELD_W{1'b0}};
  localparam logic [FIELD_W-1:0] INF_Y = {{(FIELD_W-1){1'b0}}, 1'b1};
  localparam logic [FIELD_W-1:0] INF_Z = {FIELD_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DBL_REQ = 3'd1,
    ADD_REQ = 3'd2,
    ACK     = 3'd3,
    DRAIN   = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  typedef enum logic {
    OP_DBL = 1'b0,
    OP_ADD = 1'b1
  } op_t;

endpackage

// File: rtl/ec_adder_port_mux.sv
// Operand register bank in front of the shared EC point adder.
// Operand 1 is always the accumulator R; operand 2 is R for a double and
// P for an add. Operands are captured on load and otherwise held, so they
// stay frozen for the whole time the adder request is asserted.
module ec_adder_port_mux
  import ecdsa_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  op_t                op,
  input  logic [FIELD_W-1:0] rx,
  input  logic [FIELD_W-1:0] ry,
  input  logic [FIELD_W-1:0] rz,
  input  logic [FIELD_W-1:0] px,
  input  logic [FIELD_W-1:0] py,
  input  logic [FIELD_W-1:0] pz,
  output logic [FIELD_W-1:0] add_xp,
  output logic [FIELD_W-1:0] add_yp,
  output logic [FIELD_W-1:0] add_zp,
  output logic [FIELD_W-1:0] add_xq,
  output logic [FIELD_W-1:0] add_yq,
  output logic [FIELD_W-1:0] add_zq
);

  // Capture operands on load, hold them otherwise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      add_xp <= {FIELD_W{1'b0}};
      add_yp <= {FIELD_W{1'b0}};
      add_zp <= {FIELD_W{1'b0}};
      add_xq <= {FIELD_W{1'b0}};
      add_yq <= {FIELD_W{1'b0}};
      add_zq <= {FIELD_W{1'b0}};
    end else if (load) begin
      add_xp <= rx;
      add_yp <= ry;
      add_zp <= rz;
      add_xq <= (op == OP_ADD) ? px : rx;
      add_yq <= (op == OP_ADD) ? py : ry;
      add_zq <= (op == OP_ADD) ? pz : rz;
    end else begin
      add_xp <= add_xp;
      add_yp <= add_yp;
      add_zp <= add_zp;
      add_xq <= add_xq;
      add_yq <= add_yq;
      add_zq <= add_zq;
    end
  end

endmodule

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add scheduler for R = k*P on the shared
// projective EC adder. Owns the adder start/out_read handshake.
// Optional build macro CONST_TIME_EN: issue an add for every scalar bit
// and discard the result for clear bits, giving a fixed 2*KEY_W schedule.
module ec_scalar_mult_ctrl
  import ecdsa_pkg::*;
#(
  parameter int KEY_W = 255,
  parameter int CNT_W = $clog2(KEY_W)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [KEY_W-1:0]   scalar,
  input  logic [FIELD_W-1:0] px,
  input  logic [FIELD_W-1:0] py,
  input  logic [FIELD_W-1:0] pz,
  output logic               busy,
  output logic               done,
  output logic [FIELD_W-1:0] rx,
  output logic [FIELD_W-1:0] ry,
  output logic [FIELD_W-1:0] rz,
  output logic               add_start,
  output logic               add_out_read,
  output logic [FIELD_W-1:0] add_xp,
  output logic [FIELD_W-1:0] add_yp,
  output logic [FIELD_W-1:0] add_zp,
  output logic [FIELD_W-1:0] add_xq,
  output logic [FIELD_W-1:0] add_yq,
  output logic [FIELD_W-1:0] add_zq,
  input  logic [FIELD_W-1:0] add_xr,
  input  logic [FIELD_W-1:0] add_yr,
  input  logic [FIELD_W-1:0] add_zr,
  input  logic               add_done
);

`ifdef CONST_TIME_EN
  localparam logic CONST_TIME = 1'b1;
`else
  localparam logic CONST_TIME = 1'b0;
`endif

  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(KEY_W - 1);

  state_t             state_r;
  op_t                op_r;
  logic [CNT_W-1:0]   idx_r;
  logic [KEY_W-1:0]   k_r;
  logic [FIELD_W-1:0] p_x_r;
  logic [FIELD_W-1:0] p_y_r;
  logic [FIELD_W-1:0] p_z_r;
  logic               mux_load_s;
  logic               bit_s;
  logic               take_add_s;
  logic               commit_s;

  // Decode of the current scalar bit and the resulting schedule decisions
  always_comb begin
    bit_s      = k_r[idx_r];
    take_add_s = CONST_TIME | bit_s;
    commit_s   = (op_r == OP_DBL) | bit_s;
  end

  // Operands are loaded in the first REQ cycle, before the request is raised
  always_comb begin
    mux_load_s = 1'b0;
    if (((state_r == DBL_REQ) || (state_r == ADD_REQ)) && !add_start) begin
      mux_load_s = 1'b1;
    end else begin
      mux_load_s = 1'b0;
    end
  end

  // Scheduler FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      op_r         <= OP_DBL;
      idx_r        <= IDX_TOP;
      k_r          <= {KEY_W{1'b0}};
      p_x_r        <= {FIELD_W{1'b0}};
      p_y_r        <= {FIELD_W{1'b0}};
      p_z_r        <= {FIELD_W{1'b0}};
      rx           <= INF_X;
      ry           <= INF_Y;
      rz           <= INF_Z;
      busy         <= 1'b0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_out_read <= 1'b0;
    end else begin
      done         <= 1'b0;
      add_out_read <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            k_r     <= scalar;
            p_x_r   <= px;
            p_y_r   <= py;
            p_z_r   <= pz;
            rx      <= INF_X;
            ry      <= INF_Y;
            rz      <= INF_Z;
            idx_r   <= IDX_TOP;
            op_r    <= OP_DBL;
            busy    <= 1'b1;
            state_r <= DBL_REQ;
          end
        end
        DBL_REQ, ADD_REQ: begin
          if (!add_start) begin
            add_start <= 1'b1;
          end else if (add_done) begin
            add_start    <= 1'b0;
            add_out_read <= 1'b1;
            if (commit_s) begin
              rx <= add_xr;
              ry <= add_yr;
              rz <= add_zr;
            end
            state_r <= ACK;
          end
        end
        ACK: begin
          state_r <= DRAIN;
        end
        DRAIN: begin
          // A done held past out_read must not be taken as a new result
          if (!add_done) begin
            if ((op_r == OP_DBL) && take_add_s) begin
              op_r    <= OP_ADD;
              state_r <= ADD_REQ;
            end else begin
              state_r <= NEXT;
            end
          end
        end
        NEXT: begin
          if (idx_r == {CNT_W{1'b0}}) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r - {{(CNT_W-1){1'b0}}, 1'b1};
            op_r    <= OP_DBL;
            state_r <= DBL_REQ;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  ec_adder_port_mux u_port_mux (
    .clk    (clk),
    .resetn (resetn),
    .load   (mux_load_s),
    .op     (op_r),
    .rx     (rx),
    .ry     (ry),
    .rz     (rz),
    .px     (p_x_r),
    .py     (p_y_r),
    .pz     (p_z_r),
    .add_xp (add_xp),
    .add_yp (add_yp),
    .add_zp (add_zp),
    .add_xq (add_xq),
    .add_yq (add_yq),
    .add_zq (add_zq)
  );

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Bench for ec_scalar_mult_ctrl with KEY_W=4. Points are modelled as
// integer multiples n of a generator, encoded (n : 2n+1 : 1), infinity
// (0 : 1 : 0). A behavioural adder with random latency sums multiples.
module tb_ec_scalar_mult_ctrl;
  import ecdsa_pkg::*;

  localparam int KW = 4;
`ifdef CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [KW-1:0] scalar = '0;
  logic [FIELD_W-1:0] px = '0, py = '0, pz = '0;
  logic busy, done, add_start, add_out_read;
  logic [FIELD_W-1:0] rx, ry, rz;
  logic [FIELD_W-1:0] add_xp, add_yp, add_zp, add_xq, add_yq, add_zq;
  logic [FIELD_W-1:0] add_xr = '0, add_yr = '0, add_zr = '0;
  logic add_done = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ec_scalar_mult_ctrl #(.KEY_W(KW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .scalar(scalar),
    .px(px), .py(py), .pz(pz), .busy(busy), .done(done),
    .rx(rx), .ry(ry), .rz(rz), .add_start(add_start), .add_out_read(add_out_read),
    .add_xp(add_xp), .add_yp(add_yp), .add_zp(add_zp),
    .add_xq(add_xq), .add_yq(add_yq), .add_zq(add_zq),
    .add_xr(add_xr), .add_yr(add_yr), .add_zr(add_zr), .add_done(add_done)
  );

  // Decode an encoded point to its multiple; -1 for a malformed point
  function automatic int dec(input logic [FIELD_W-1:0] x, input logic [FIELD_W-1:0] y,
                             input logic [FIELD_W-1:0] z);
    if (z == FIELD_W'(0)) return (x == FIELD_W'(0) && y == FIELD_W'(1)) ? 0 : -1;
    if (z == FIELD_W'(1) && x < FIELD_W'(1000) && y == (x << 1) + FIELD_W'(1))
      return int'(x[15:0]);
    return -1;
  endfunction

  // Behavioural adder: random latency, done held until out_read (+ hold_cfg cycles)
  int a_st = 0, a_lat = 0, a_hold = 0, hold_cfg = 0;
  int req_cnt = 0, stab_err = 0, done_cnt = 0;
  int rec_np[1024];
  int rec_nq[1024];
  logic [FIELD_W-1:0] cxp, cyp, czp, cxq, cyq, czq;

  // Adder request/response model
  always @(posedge clk) begin
    int n1, n2, s;
    if (!resetn) begin
      a_st <= 0;
      add_done <= 1'b0;
    end else begin
      case (a_st)
        0: if (add_start) begin
          cxp <= add_xp; cyp <= add_yp; czp <= add_zp;
          cxq <= add_xq; cyq <= add_yq; czq <= add_zq;
          if (req_cnt < 1024) begin
            rec_np[req_cnt] <= dec(add_xp, add_yp, add_zp);
            rec_nq[req_cnt] <= dec(add_xq, add_yq, add_zq);
          end
          req_cnt <= req_cnt + 1;
          a_lat <= int'($urandom_range(3, 20));
          a_st <= 1;
        end
        1: begin
          if (add_xp !== cxp || add_yp !== cyp || add_zp !== czp ||
              add_xq !== cxq || add_yq !== cyq || add_zq !== czq)
            stab_err <= stab_err + 1;
          if (a_lat <= 1) begin
            n1 = dec(cxp, cyp, czp);
            n2 = dec(cxq, cyq, czq);
            s = n1 + n2;
            if (n1 < 0 || n2 < 0) begin
              add_xr <= FIELD_W'(5); add_yr <= FIELD_W'(0); add_zr <= FIELD_W'(1);
            end else if (s == 0) begin
              add_xr <= FIELD_W'(0); add_yr <= FIELD_W'(1); add_zr <= FIELD_W'(0);
            end else begin
              add_xr <= FIELD_W'(s); add_yr <= FIELD_W'(2 * s + 1); add_zr <= FIELD_W'(1);
            end
            add_done <= 1'b1;
            a_st <= 2;
          end else begin
            a_lat <= a_lat - 1;
          end
        end
        2: if (add_out_read) begin
          if (hold_cfg == 0) begin
            add_done <= 1'b0;
            a_st <= 0;
          end else begin
            a_hold <= hold_cfg;
            a_st <= 3;
          end
        end
        3: if (a_hold <= 1) begin
          add_done <= 1'b0;
          a_st <= 0;
        end else begin
          a_hold <= a_hold - 1;
        end
        default: a_st <= 0;
      endcase
    end
  end

  // Count done pulses
  always @(posedge clk) begin
    if (resetn && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic [FIELD_W-1:0] obs,
                       input logic [FIELD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scalar multiplication checked against the double-and-add reference
  task automatic run(input logic [KW-1:0] k, input int m, input int hold, input bit mid_start);
    int exp_np[16];
    int exp_nq[16];
    int ne, r, base, dbase, sbase;
    bit got;
    r = 0; ne = 0;
    for (int i = KW - 1; i >= 0; i--) begin
      exp_np[ne] = r; exp_nq[ne] = r; ne++;
      r = 2 * r;
      if (k[i] || CT) begin
        exp_np[ne] = r; exp_nq[ne] = m; ne++;
        if (k[i]) r = r + m;
      end
    end
    hold_cfg = hold;
    @(negedge clk);
    base = req_cnt; dbase = done_cnt; sbase = stab_err;
    scalar = k; px = FIELD_W'(m); py = FIELD_W'(2 * m + 1); pz = FIELD_W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_i("busy_rise", int'(busy), 1);
    if (mid_start) begin
      repeat (25) @(negedge clk);
      scalar = 4'b0110; px = FIELD_W'(7); py = FIELD_W'(15); pz = FIELD_W'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk_i("done_seen", int'(got), 1);
    chk_i("req_count", req_cnt - base, ne);
    for (int i = 0; i < ne && i < req_cnt - base; i++) begin
      chk_i("op_r_operand", rec_np[base + i], exp_np[i]);
      chk_i("op_q_operand", rec_nq[base + i], exp_nq[i]);
    end
    chk_f("rx", rx, (r == 0) ? FIELD_W'(0) : FIELD_W'(r));
    chk_f("ry", ry, FIELD_W'(2 * r + 1));
    chk_f("rz", rz, (r == 0) ? FIELD_W'(0) : FIELD_W'(1));
    @(negedge clk);
    chk_i("busy_after", int'(busy), 0);
    chk_i("done_single_cycle", int'(done), 0);
    chk_i("done_pulses", done_cnt - dbase, 1);
    chk_i("operand_stability", stab_err - sbase, 0);
    chk_f("rx_held", rx, (r == 0) ? FIELD_W'(0) : FIELD_W'(r));
  endtask

  initial begin
    int base;
    bit got;
    // Reset state
    repeat (2) @(negedge clk);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_add_start", int'(add_start), 0);
    chk_i("rst_out_read", int'(add_out_read), 0);
    chk_f("rst_rx", rx, INF_X);
    chk_f("rst_ry", ry, INF_Y);
    chk_f("rst_rz", rz, INF_Z);
    resetn = 1'b1;
    @(negedge clk);

    // Directed scalars
    run(4'b0001, 1, 0, 1'b0);
    run(4'b0000, 1, 0, 1'b0);
    run(4'b1011, 1, 0, 1'b0);
    // Adder holding done after out_read
    run(4'b1011, 1, 5, 1'b0);
    // Start pulse mid-run is ignored
    run(4'b1111, 1, 0, 1'b1);

    // Randomized scalars, base points and done hold times
    for (int n = 0; n < 6; n++)
      run(KW'($urandom_range(0, 15)), int'($urandom_range(1, 9)), int'($urandom_range(0, 3)), 1'b0);

    // Reset during the third request
    @(negedge clk);
    base = req_cnt;
    hold_cfg = 0;
    scalar = 4'b1111; px = FIELD_W'(1); py = FIELD_W'(3); pz = FIELD_W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      if (req_cnt - base >= 3) got = 1'b1;
    end
    chk_i("third_req_seen", int'(got), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk_i("mid_rst_add_start", int'(add_start), 0);
    chk_i("mid_rst_busy", int'(busy), 0);
    chk_f("mid_rst_rx", rx, INF_X);
    chk_f("mid_rst_ry", ry, INF_Y);
    chk_f("mid_rst_rz", rz, INF_Z);
    resetn = 1'b1;
    @(negedge clk);
    run(4'b0010, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
